// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the IF/ID register.
// Handshakes: a request transfers on a cycle with imem_req_o && imem_gnt_i; the
// request holds its address until granted or replaced by a redirect. Responses
// return in order, one per imem_rvalid_i pulse. The head instruction transfers
// to IF/ID on a cycle with if_valid_o && if_ready_i.
interface if_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_instaddr_o;
    logic        if_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, if_valid_o, if_inst_o, if_instaddr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, if_valid_o, if_inst_o, if_instaddr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credited pipelined fetches and
// buffers in-order responses, discarding stale ones via a 1-bit epoch tag.
module if_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  prd_jump_en_i,
    input  logic [31:0]           prd_jump_base_i,
    input  logic [31:0]           prd_jump_ofset_i,
    input  logic                  ex_redirect_en_i,
    input  logic [31:0]           ex_redirect_addr_i,
    if_fetch_unit_if.master       bus,
    output logic [1:0]            dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FULL = 2'd2} state_t;

    state_t        state, state_next;
    logic [31:0]   pc;
    logic          epoch;
    logic [PW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] buf_count, buf_count_next;
    logic          granted_since_reset;

    logic          tag_epoch [DEPTH];
    logic [31:0]   tag_addr  [DEPTH];
    logic [31:0]   buf_inst  [DEPTH];
    logic [31:0]   buf_addr  [DEPTH];

    logic          redirect, credit_ok, credit_next_ok, req, grant, rsp, push, pop, head_valid;
    logic [31:0]   target;

    always_comb begin
        redirect   = ex_redirect_en_i | prd_jump_en_i;
        target     = ex_redirect_en_i ? ex_redirect_addr_i
                                      : ((prd_jump_base_i + prd_jump_ofset_i) & ~32'h1);
        credit_ok  = (outstanding + buf_count) < CW'(DEPTH);
        req        = !rstn && (state != FULL) && credit_ok;
        grant      = req && bus.imem_gnt_i;
        // A response with no tag waiting (e.g. left over from before reset) is ignored.
        rsp        = bus.imem_rvalid_i && (outstanding != '0);
        push       = rsp && (tag_epoch[tag_rd] == (epoch ^ redirect));
        head_valid = (buf_count != '0) && !redirect;
        pop        = head_valid && bus.if_ready_i;

        outstanding_next = outstanding;
        case ({grant, rsp})
            2'b10:   outstanding_next = outstanding + CW'(1);
            2'b01:   outstanding_next = outstanding - CW'(1);
            default: outstanding_next = outstanding;
        endcase

        buf_count_next = buf_count;
        if (redirect) begin
            buf_count_next = CW'(push);
        end else begin
            case ({push, pop})
                2'b10:   buf_count_next = buf_count + CW'(1);
                2'b01:   buf_count_next = buf_count - CW'(1);
                default: buf_count_next = buf_count;
            endcase
        end
        credit_next_ok = (outstanding_next + buf_count_next) < CW'(DEPTH);
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = credit_next_ok ? RUN : FULL;
        end else begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = credit_next_ok ? RUN : FULL;
                FULL:    state_next = credit_next_ok ? RUN : FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state               <= IDLE;
            pc                  <= RESET_ADDR;
            epoch               <= 1'b0;
            tag_wr              <= '0;
            tag_rd              <= '0;
            buf_wr              <= '0;
            buf_rd              <= '0;
            outstanding         <= '0;
            buf_count           <= '0;
            granted_since_reset <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            buf_count   <= buf_count_next;
            if (redirect)   pc <= target;
            else if (grant) pc <= pc + 32'd4;
            if (redirect)   epoch <= ~epoch;
            if (grant)      tag_wr <= tag_wr + PW'(1);
            if (grant)      granted_since_reset <= 1'b1;
            if (rsp)        tag_rd <= tag_rd + PW'(1);
            if (push)       buf_wr <= buf_wr + PW'(1);
            // A flush leaves the read pointer on the slot a same-cycle push fills.
            if (redirect)   buf_rd <= buf_wr;
            else if (pop)   buf_rd <= buf_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_epoch[tag_wr] <= epoch;
            tag_addr[tag_wr]  <= pc;
        end
        if (push) begin
            buf_inst[buf_wr] <= bus.imem_rdata_i;
            buf_addr[buf_wr] <= tag_addr[tag_rd];
        end
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc;
    assign bus.if_valid_o    = head_valid;
    assign bus.if_inst_o     = head_valid ? buf_inst[buf_rd] : NOP_INST;
    assign bus.if_instaddr_o = head_valid ? buf_addr[buf_rd] : 32'h0;
    assign dbg_state         = state;

    a_rvalid_has_tag: assert property (@(posedge clk) disable iff (rstn)
        (bus.imem_rvalid_i && granted_since_reset) |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rstn)
        !(push && !pop && !redirect && (buf_count == CW'(DEPTH))));
    a_addr_aligned: assert property (@(posedge clk) disable iff (rstn)
        bus.imem_req_o |-> (bus.imem_addr_o[1:0] == 2'b00));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory responder, issue/delivery scoreboards
// and point checks around redirects, credit stalls, PC wrap and reset.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic        prd_jump_en_i, ex_redirect_en_i;
    logic [31:0] prd_jump_base_i, prd_jump_ofset_i, ex_redirect_addr_i;
    logic [1:0]  dbg_state;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_ADDR(32'h0000_0000), .DEPTH(2), .NOP_INST(32'h0000_0013)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .prd_jump_en_i      (prd_jump_en_i),
        .prd_jump_base_i    (prd_jump_base_i),
        .prd_jump_ofset_i   (prd_jump_ofset_i),
        .ex_redirect_en_i   (ex_redirect_en_i),
        .ex_redirect_addr_i (ex_redirect_addr_i),
        .bus                (bus),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];      // expected deliveries {addr, inst}
    logic [31:0] exp_iss_q[$];  // expected granted fetch addresses
    logic [31:0] rsp_q[$];      // memory responses pending
    int          checks = 0;
    int          errors = 0;
    int          gnt_budget = 0;
    bit          rsp_en = 1'b1;
    logic [31:0] mem_a;
    logic [63:0] mon_exp;
    logic [31:0] iss_exp;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        exp_iss_q.push_back(a);
        if (delivered) exp_q.push_back({a, inst_of(a)});
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_en && rsp_q.size() > 0) begin
                mem_a             = rsp_q.pop_front();
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = inst_of(mem_a);
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = 32'hDEAD_BEEF;
            end
            bus.imem_gnt_i = (gnt_budget > 0);
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                gnt_budget--;
                rsp_q.push_back(bus.imem_addr_o);
                if (exp_iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue: unexpected grant at %h", bus.imem_addr_o);
                end else begin
                    iss_exp = exp_iss_q.pop_front();
                    check("issue_addr", {32'h0, bus.imem_addr_o}, {32'h0, iss_exp});
                end
            end
        end
    end

    // ---------------- delivery monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rstn && bus.if_valid_o && bus.if_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver: unexpected %h @ %h", bus.if_inst_o, bus.if_instaddr_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("deliver", {bus.if_instaddr_o, bus.if_inst_o}, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_prd(input logic [31:0] b, input logic [31:0] o);
        prd_jump_en_i = 1'b1; prd_jump_base_i = b; prd_jump_ofset_i = o;
        @(negedge clk);
        prd_jump_en_i = 1'b0;
    endtask

    task automatic drive_ex(input logic [31:0] a);
        ex_redirect_en_i = 1'b1; ex_redirect_addr_i = a;
        @(negedge clk);
        ex_redirect_en_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (exp_iss_q.size() == 0) && (rsp_q.size() == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: drain timeout, exp_q=%0d exp_iss_q=%0d rsp_q=%0d",
                     name, exp_q.size(), exp_iss_q.size(), rsp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},      {63'h0, bus.imem_req_o},      64'h0);
        check({tag, "_valid"},    {63'h0, bus.if_valid_o},      64'h0);
        check({tag, "_inst"},     {32'h0, bus.if_inst_o},       64'h13);
        check({tag, "_instaddr"}, {32'h0, bus.if_instaddr_o},   64'h0);
        check({tag, "_state"},    {62'h0, dbg_state},           64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b1;
        prd_jump_en_i = 1'b0; prd_jump_base_i = 32'h0; prd_jump_ofset_i = 32'h0;
        ex_redirect_en_i = 1'b0; ex_redirect_addr_i = 32'h0;
        bus.if_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #2 check_reset_outputs("reset");

        // Sequential fetch 0,4,8,C and first-delivery latency.
        @(negedge clk);
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4), 1'b1);
        gnt_budget = 4;
        rstn = 1'b0;
        #2;
        check("first_req",  {63'h0, bus.imem_req_o}, 64'h1);
        check("first_addr", {32'h0, bus.imem_addr_o}, 64'h0);
        @(negedge clk); #2;
        check("valid_lat1", {63'h0, bus.if_valid_o}, 64'h0);
        @(negedge clk); #2;
        check("valid_lat2", {63'h0, bus.if_valid_o}, 64'h1);
        wait_idle("seq");

        // Ready low: buffer fills to two entries and requests stop.
        bus.if_ready_i = 1'b0;
        expect_fetch(32'h10, 1'b1);
        expect_fetch(32'h14, 1'b1);
        gnt_budget = 2;
        repeat (6) @(negedge clk);
        #2;
        check("full_req",   {63'h0, bus.imem_req_o}, 64'h0);
        check("full_state", {62'h0, dbg_state},      64'h2);
        check("full_head",  {31'h0, bus.if_valid_o, bus.if_instaddr_o}, {31'h0, 1'b1, 32'h10});
        @(negedge clk);
        expect_fetch(32'h18, 1'b1);
        expect_fetch(32'h1C, 1'b1);
        gnt_budget = 2;
        bus.if_ready_i = 1'b1;
        wait_idle("stall");

        // Predicted redirect with 0x108/0x10C in flight; both must be dropped.
        rsp_en = 1'b0;
        drive_ex(32'h108);
        expect_fetch(32'h108, 1'b0);
        expect_fetch(32'h10C, 1'b0);
        gnt_budget = 2;
        repeat (2) @(negedge clk);
        drive_prd(32'h100, 32'hFFFF_FFF0);
        #2;
        check("prd_addr",  {32'h0, bus.imem_addr_o}, 64'hF0);
        check("prd_state", {62'h0, dbg_state},       64'h2);
        expect_fetch(32'hF0, 1'b1);
        gnt_budget = 1;
        rsp_en = 1'b1;
        wait_idle("prd");

        // EX beats predictor in the same cycle.
        ex_redirect_en_i = 1'b1; ex_redirect_addr_i = 32'h200;
        drive_prd(32'h300, 32'h0);
        ex_redirect_en_i = 1'b0;
        #2 check("ex_prio", {32'h0, bus.imem_addr_o}, 64'h200);
        expect_fetch(32'h200, 1'b1);
        gnt_budget = 1;
        wait_idle("ex_prio");

        // Redirect in the granting cycle: 0x204 carries the old epoch.
        expect_fetch(32'h204, 1'b0);
        gnt_budget = 1;
        drive_prd(32'h41, 32'h0);
        #2 check("jalr_addr", {32'h0, bus.imem_addr_o}, 64'h40);
        expect_fetch(32'h40, 1'b1);
        gnt_budget = 1;
        wait_idle("same_cycle");

        // PC wrap from 0xFFFF_FFFC to 0.
        drive_ex(32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0, 1'b1);
        gnt_budget = 2;
        wait_idle("wrap");
        check("wrap_pc", {32'h0, bus.imem_addr_o}, 64'h4);

        // Reset with one request in flight; its late response must be ignored.
        rsp_en = 1'b0;
        expect_fetch(32'h4, 1'b0);
        gnt_budget = 1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #2;
        check_reset_outputs("midrst");
        @(negedge clk);
        gnt_budget = 0;
        rstn = 1'b0;
        rsp_en = 1'b1;
        @(negedge clk); #2;
        check("late_rvalid_valid", {63'h0, bus.if_valid_o}, 64'h0);
        check("late_rvalid_addr",  {32'h0, bus.imem_addr_o}, 64'h0);
        expect_fetch(32'h0, 1'b1);
        gnt_budget = 1;
        wait_idle("post_reset");

        check("exp_q_empty",     64'(exp_q.size()),     64'h0);
        check("exp_iss_q_empty", 64'(exp_iss_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage that owns the PC and feeds the IF/ID register.
- It consumes redirects from the ID-stage static branch predictor (base + offset) and from the EX-stage mispredict correction.
- It issues pipelined requests to instruction memory over a req/gnt/rvalid handshake.
- It buffers returned instructions and drops stale responses after a redirect using an epoch tag.

Parameters:
- RESET_ADDR, 32'h0000_0000: PC value after reset.
- DEPTH, 2: response buffer depth; also the credit limit on (outstanding requests + buffered entries). Must be a power of 2, ≥ 2.
- NOP_INST, 32'h0000_0013: value driven on if_inst_o when no valid instruction is present.

Ports:
- clk, in, 1: clock, rising edge.
- rstn, in, 1: reset. Synchronous and active-high; rstn=1 resets on the clock edge.
- prd_jump_en_i, in, 1: ID-stage predicted redirect.
- prd_jump_base_i, in, 32: predicted target base.
- prd_jump_ofset_i, in, 32: predicted target offset.
- ex_redirect_en_i, in, 1: EX-stage mispredict correction.
- ex_redirect_addr_i, in, 32: corrected PC.
- imem_req_o, out, 1: fetch request.
- imem_addr_o, out, 32: fetch address, word-aligned.
- imem_gnt_i, in, 1: request accepted this cycle.
- imem_rvalid_i, in, 1: response data valid. Responses return in order, at least 1 cycle after gnt.
- imem_rdata_i, in, 32: response instruction.
- if_valid_o, out, 1: buffer head valid toward IF/ID.
- if_inst_o, out, 32: head instruction.
- if_instaddr_o, out, 32: head instruction address.
- if_ready_i, in, 1: IF/ID accepts head (deasserted by ctrl on stall).

Behaviour:
- Reset (rstn=1):
  - pc=RESET_ADDR, epoch=0.
  - Tag FIFO and response buffer empty; outstanding count = 0.
  - imem_req_o=0, if_valid_o=0, if_inst_o=NOP_INST, if_instaddr_o=0.
  - Reset mid-transaction abandons everything; any rvalid arriving afterwards with no tag present is ignored.
- First request: imem_req_o rises in the first cycle with rstn=0.
- Redirect target selection (priority high to low): rstn > ex_redirect_en_i > prd_jump_en_i > sequential.
  - Predicted target = (prd_jump_base_i + prd_jump_ofset_i) mod 2^32, with bit0 cleared.
  - EX address is used as given.
- Redirect effect, same cycle as the redirect input:
  - next pc = target.
  - epoch toggles.
  - Response buffer flushed; if_valid_o=0 next cycle.
  - A redirect forces if_valid_o=0 in its own cycle's pop decision: no pop.
- Request issue:
  - imem_req_o=1 when credits are available: outstanding + buffered < DEPTH.
  - imem_addr_o=pc.
  - While req is high without gnt, the address is held stable unless a redirect occurs. A redirect may replace the address (abort of an ungranted request).
- Grant: on req && gnt, pc <= pc+4 (wraps 0xFFFF_FFFC -> 0) and {epoch, addr} are pushed to the tag FIFO.
  - If a redirect occurs in the same cycle, the granted entry carries the OLD epoch and pc loads the target.
- Response: on rvalid, pop the tag FIFO.
  - If the tag epoch equals the current epoch (after any same-cycle toggle), push {rdata, addr} to the buffer.
  - Otherwise drop the response and free its credit.
- Output pop: if_valid_o && if_ready_i removes the head.
  - Push and pop in the same cycle are allowed when full (the credit guarantees no overflow).
- Credits: outstanding count increments on grant, decrements on rvalid. Simultaneous grant and rvalid leave it unchanged.
- State machine, 3 states:
  - IDLE: the single reset-exit cycle. Transitions to RUN.
  - RUN: issuing requests. Transitions to FULL when credits = 0.
  - FULL: no requests issued. Returns to RUN when a credit frees (pop or dropped response).
  - Redirect in any state: next state is RUN if credits are then available, else FULL.
- Latency: if_valid_o rises in the cycle after rvalid for a current-epoch response.
- Assertions:
  - rvalid with an empty tag FIFO: protocol error, response ignored.
  - No buffer overflow.
  - imem_addr_o[1:0]=0 while imem_req_o=1.

Test Plan:
- Reset release, memory with gnt always 1 and rvalid 1 cycle later, if_ready_i=1:
  - Fetch addresses 0,4,8,C back-to-back.
  - if_valid_o first high 2 cycles after the first req.
- if_ready_i=0 held:
  - Buffer fills to 2 entries; imem_req_o drops (FULL).
  - Raising ready resumes requests; no instruction is lost or duplicated.
- prd_jump_en_i=1, base=0x100, ofset=0xFFFF_FFF0, while 2 requests (0x108, 0x10C) are in flight:
  - Next request address 0xF0.
  - Responses for 0x108/0x10C are dropped.
  - First delivered if_instaddr_o=0xF0.
- ex_redirect_en_i and prd_jump_en_i in the same cycle (EX addr 0x200, predicted 0x300):
  - Next fetch address 0x200.
- Redirect in the same cycle as a grant:
  - The granted response carries the old epoch and is dropped.
  - Jalr-style base 0x41 + ofset 0 gives target 0x40.
- PC at 0xFFFF_FFFC granted:
  - Next address 0x0000_0000.
  - Sync reset asserted while 1 request is in flight: outputs return to reset values next cycle, and the late rvalid is ignored.
